// File: rtl/ddr2_read_checker_if.sv
// Snoop/result bundle for ddr2_read_checker: controller command side, read-return side
// and the statistics exported to the top-level bench.
interface ddr2_read_checker_if #(
   parameter int CNT_W  = 16,
   parameter int PEND_W = 10
) ();
   logic [2:0]        cmd;
   logic [1:0]        sz;
   logic [24:0]       addr;
   logic [15:0]       din;
   logic              fetching;
   logic              notfull;
   logic              validout;
   logic [15:0]       dout;
   logic [24:0]       raddr;
   logic [CNT_W-1:0]  match_count;
   logic [CNT_W-1:0]  err_count;
   logic [CNT_W-1:0]  unchecked_count;
   logic [CNT_W-1:0]  spurious_count;
   logic [PEND_W-1:0] pending_reads;
   logic              err_flag;
   logic [24:0]       first_err_addr;
   logic [15:0]       first_err_exp;
   logic [15:0]       first_err_got;
   logic              idle;

   modport master (
      output cmd, sz, addr, din, fetching, notfull, validout, dout, raddr,
      input  match_count, err_count, unchecked_count, spurious_count, pending_reads,
             err_flag, first_err_addr, first_err_exp, first_err_got, idle
   );

   modport slave (
      input  cmd, sz, addr, din, fetching, notfull, validout, dout, raddr,
      output match_count, err_count, unchecked_count, spurious_count, pending_reads,
             err_flag, first_err_addr, first_err_exp, first_err_got, idle
   );
endinterface

// File: rtl/ddr2_read_checker.sv
// Read-return scoreboard for ddr2_controller: shadows written data in a tagged,
// direct-mapped memory and classifies every returned read word against it.
module ddr2_read_checker #(
   parameter int SHADOW_AW = 8,
   parameter int CNT_W     = 16,
   parameter int PEND_W    = 10
) (
   input  logic               clk,
   input  logic               reset,
   ddr2_read_checker_if.slave bus
);
   localparam int DEPTH = 1 << SHADOW_AW;
   localparam int TAG_W = 25 - SHADOW_AW;
   localparam logic [2:0] C_SCR = 3'b001;
   localparam logic [2:0] C_SCW = 3'b010;
   localparam logic [2:0] C_BLR = 3'b011;
   localparam logic [2:0] C_BLW = 3'b100;
   localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

   typedef enum logic {S_IDLE, S_WDATA} state_t;

   state_t              r_state, w_state_nxt;
   logic [24:0]         r_wptr;
   logic [5:0]          r_wleft;
   logic [PEND_W-1:0]   r_pending;
   logic [DEPTH-1:0]    r_sh_valid;
   logic [TAG_W-1:0]    r_sh_tag  [DEPTH];
   logic [15:0]         r_sh_data [DEPTH];

   logic                r_chk_v, r_chk_spur, r_chk_hit_v, r_chk_tag_eq;
   logic [15:0]         r_chk_exp, r_chk_got;
   logic [24:0]         r_chk_addr;
   logic [CNT_W-1:0]    r_match, r_err, r_unchk, r_spur;
   logic                r_err_flag;
   logic [24:0]         r_fe_addr;
   logic [15:0]         r_fe_exp, r_fe_got;

   logic                w_accept, w_wr_start, w_shwr, w_dec;
   logic [5:0]          w_blen;
   logic [PEND_W:0]     w_pend_add, w_pend_sum;
   logic [SHADOW_AW-1:0] w_widx, w_ridx;

   assign w_accept   = bus.notfull && (bus.cmd >= C_SCR) && (bus.cmd <= C_BLW);
   assign w_blen     = {({1'b0, bus.sz} + 3'd1), 3'b000};
   assign w_wr_start = (r_state == S_IDLE) && w_accept &&
                       ((bus.cmd == C_SCW) || (bus.cmd == C_BLW));
   assign w_shwr     = (r_state == S_WDATA) && bus.fetching;
   assign w_widx     = r_wptr[SHADOW_AW-1:0];
   assign w_ridx     = bus.raddr[SHADOW_AW-1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_wr_start) w_state_nxt = S_WDATA;
         S_WDATA: if (w_shwr && (r_wleft == 6'd1)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_wleft <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_start) begin
            r_wptr  <= bus.addr;
            r_wleft <= (bus.cmd == C_SCW) ? 6'd1 : w_blen;
         end else if (w_shwr) begin
            r_wptr  <= r_wptr + 25'd1;
            r_wleft <= r_wleft - 6'd1;
         end
      end
   end

   // A spurious word does not consume a pending read, so the count never goes below zero.
   always_comb begin
      w_pend_add = '0;
      if (w_accept && (bus.cmd == C_SCR)) w_pend_add = (PEND_W+1)'(1);
      if (w_accept && (bus.cmd == C_BLR)) w_pend_add = (PEND_W+1)'(w_blen);
      w_dec      = bus.validout && (r_pending != '0);
      w_pend_sum = {1'b0, r_pending} + w_pend_add - (PEND_W+1)'(w_dec);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_pending <= '0;
      else        r_pending <= (w_pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0]
                                                       : w_pend_sum[PEND_W-1:0];
   end

   // Shadow arrays are read and written in the same process: reads see the old entry.
   always_ff @(posedge clk) begin
      if (w_shwr) begin
         r_sh_tag[w_widx]  <= r_wptr[24:SHADOW_AW];
         r_sh_data[w_widx] <= bus.din;
      end
      r_chk_tag_eq <= (r_sh_tag[w_ridx] == bus.raddr[24:SHADOW_AW]);
      r_chk_exp    <= r_sh_data[w_ridx];
      r_chk_got    <= bus.dout;
      r_chk_addr   <= bus.raddr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh_valid  <= '0;
         r_chk_v     <= 1'b0;
         r_chk_spur  <= 1'b0;
         r_chk_hit_v <= 1'b0;
      end else begin
         if (w_shwr) r_sh_valid[w_widx] <= 1'b1;
         r_chk_v     <= bus.validout;
         r_chk_spur  <= (r_pending == '0);
         r_chk_hit_v <= r_sh_valid[w_ridx];
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_match    <= '0;
         r_err      <= '0;
         r_unchk    <= '0;
         r_spur     <= '0;
         r_err_flag <= 1'b0;
         r_fe_addr  <= '0;
         r_fe_exp   <= '0;
         r_fe_got   <= '0;
      end else if (r_chk_v) begin
         if (r_chk_spur) begin
            r_spur     <= sat_inc(r_spur);
            r_err_flag <= 1'b1;
            if (!r_err_flag) begin
               r_fe_addr <= r_chk_addr;
               r_fe_exp  <= '0;
               r_fe_got  <= r_chk_got;
            end
         end else if (!r_chk_hit_v || !r_chk_tag_eq) begin
            r_unchk <= sat_inc(r_unchk);
         end else if (r_chk_exp == r_chk_got) begin
            r_match <= sat_inc(r_match);
         end else begin
            r_err      <= sat_inc(r_err);
            r_err_flag <= 1'b1;
            if (!r_err_flag) begin
               r_fe_addr <= r_chk_addr;
               r_fe_exp  <= r_chk_exp;
               r_fe_got  <= r_chk_got;
            end
         end
      end
   end

   assign bus.match_count     = r_match;
   assign bus.err_count       = r_err;
   assign bus.unchecked_count = r_unchk;
   assign bus.spurious_count  = r_spur;
   assign bus.pending_reads   = r_pending;
   assign bus.err_flag        = r_err_flag;
   assign bus.first_err_addr  = r_fe_addr;
   assign bus.first_err_exp   = r_fe_exp;
   assign bus.first_err_got   = r_fe_got;
   assign bus.idle            = (r_state == S_IDLE) && (r_pending == '0);
endmodule

// File: tb/tb_ddr2_read_checker.sv
// Randomized bench for ddr2_read_checker; expectations come from an address-keyed
// shadow model and per-word classification kept in the bench.
module tb_ddr2_read_checker;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ddr2_read_checker_if #(.CNT_W(16), .PEND_W(10)) bus ();
   ddr2_read_checker #(.SHADOW_AW(AW), .CNT_W(16), .PEND_W(10)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   // Model: one entry per shadow slot, remembering the full word address last written there.
   bit          m_valid [1<<AW];
   logic [24:0] m_addr  [1<<AW];
   logic [15:0] m_data  [1<<AW];
   int m_match, m_err, m_unchk, m_spur, m_pend;
   bit m_flag;
   logic [24:0] m_fa;
   logic [15:0] m_fe, m_fg;
   logic [15:0] bufd [32];

   task automatic model_reset();
      for (int i = 0; i < (1<<AW); i++) m_valid[i] = 1'b0;
      m_match = 0; m_err = 0; m_unchk = 0; m_spur = 0; m_pend = 0;
      m_flag = 1'b0; m_fa = '0; m_fe = '0; m_fg = '0;
   endtask

   task automatic idle_inputs();
      bus.cmd = '0; bus.sz = '0; bus.addr = '0; bus.din = '0; bus.fetching = 1'b0;
      bus.notfull = 1'b1; bus.validout = 1'b0; bus.dout = '0; bus.raddr = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic model_ret(input logic [24:0] a, input logic [15:0] d);
      int idx;
      idx = int'(a[AW-1:0]);
      if (m_pend == 0) begin
         m_spur++;
         if (!m_flag) begin m_fa = a; m_fe = '0; m_fg = d; m_flag = 1'b1; end
      end else begin
         m_pend--;
         if (!(m_valid[idx] && m_addr[idx] == a)) m_unchk++;
         else if (m_data[idx] == d) m_match++;
         else begin
            m_err++;
            if (!m_flag) begin m_fa = a; m_fe = m_data[idx]; m_fg = d; m_flag = 1'b1; end
         end
      end
   endtask

   task automatic do_write(input bit blk, input logic [24:0] a, input logic [1:0] s);
      int n;
      logic [24:0] wa;
      n = blk ? 8 * (int'(s) + 1) : 1;
      @(negedge clk);
      bus.cmd = blk ? 3'b100 : 3'b010; bus.addr = a; bus.sz = s;
      @(negedge clk);
      bus.cmd = '0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.fetching = 1'b0;
            @(negedge clk);
         end
         wa = a + 25'(i);
         bus.fetching = 1'b1; bus.din = bufd[i];
         m_valid[int'(wa[AW-1:0])] = 1'b1;
         m_addr[int'(wa[AW-1:0])]  = wa;
         m_data[int'(wa[AW-1:0])]  = bufd[i];
         @(negedge clk);
      end
      bus.fetching = 1'b0;
   endtask

   task automatic do_read(input bit blk, input logic [24:0] a, input logic [1:0] s);
      bus.cmd = blk ? 3'b011 : 3'b001; bus.addr = a; bus.sz = s;
      m_pend = m_pend + (blk ? 8 * (int'(s) + 1) : 1);
      if (m_pend > 1023) m_pend = 1023;
      @(negedge clk);
      bus.cmd = '0;
   endtask

   task automatic ret_word(input logic [24:0] a, input logic [15:0] d);
      bus.validout = 1'b1; bus.raddr = a; bus.dout = d;
      model_ret(a, d);
      @(negedge clk);
      bus.validout = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.match_count !== 16'd0 || bus.err_count !== 16'd0 ||
          bus.unchecked_count !== 16'd0 || bus.spurious_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_counts got m=%0d e=%0d u=%0d s=%0d want all 0", bus.match_count,
                  bus.err_count, bus.unchecked_count, bus.spurious_count);
      end
      checks++;
      if (bus.pending_reads !== 10'd0 || bus.idle !== 1'b1 || bus.err_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got pend=%0d idle=%b flag=%b want 0/1/0",
                  bus.pending_reads, bus.idle, bus.err_flag);
      end
   endtask

   task automatic test_single();
      bufd[0] = 16'hA5A5;
      do_write(1'b0, 25'h10, 2'd0);
      do_read(1'b0, 25'h10, 2'd0);
      checks++;
      if (bus.pending_reads !== 10'd1 || bus.idle !== 1'b0) begin
         failures++;
         $display("FAIL single_pending got pend=%0d idle=%b want 1/0", bus.pending_reads, bus.idle);
      end
      ret_word(25'h10, 16'hA5A5);
      settle();
      checks++;
      if (bus.match_count !== 16'(m_match) || bus.err_count !== 16'd0 || bus.idle !== 1'b1) begin
         failures++;
         $display("FAIL single_match got m=%0d e=%0d idle=%b want %0d/0/1",
                  bus.match_count, bus.err_count, bus.idle, m_match);
      end
   endtask

   task automatic test_burst_err();
      for (int i = 0; i < 8; i++) bufd[i] = 16'h1000 + 16'(i);
      do_write(1'b1, 25'hF8, 2'd0);
      do_read(1'b1, 25'hF8, 2'd0);
      checks++;
      if (bus.pending_reads !== 10'd8) begin
         failures++;
         $display("FAIL burst_pending got %0d want 8", bus.pending_reads);
      end
      for (int i = 0; i < 8; i++)
         ret_word(25'hF8 + 25'(i), (i == 3) ? 16'hDEAD : 16'h1000 + 16'(i));
      settle();
      checks++;
      if (bus.match_count !== 16'(m_match) || bus.err_count !== 16'(m_err) ||
          bus.err_flag !== 1'b1) begin
         failures++;
         $display("FAIL burst_counts got m=%0d e=%0d f=%b want %0d/%0d/1",
                  bus.match_count, bus.err_count, bus.err_flag, m_match, m_err);
      end
      checks++;
      if (bus.first_err_addr !== 25'hFB || bus.first_err_exp !== 16'h1003 ||
          bus.first_err_got !== 16'hDEAD) begin
         failures++;
         $display("FAIL burst_first_err got a=%h x=%h g=%h want 00000fb/1003/dead",
                  bus.first_err_addr, bus.first_err_exp, bus.first_err_got);
      end
   endtask

   task automatic test_wrap();
      logic [24:0] a;
      for (int i = 0; i < 8; i++) bufd[i] = 16'($urandom);
      do_write(1'b1, 25'h1FFFFFE, 2'd0);
      do_read(1'b1, 25'h1FFFFFE, 2'd0);
      for (int i = 0; i < 8; i++) begin
         a = 25'h1FFFFFE + 25'(i);
         ret_word(a, bufd[i]);
      end
      settle();
      checks++;
      if (bus.match_count !== 16'(m_match) || bus.unchecked_count !== 16'(m_unchk) ||
          bus.err_count !== 16'(m_err)) begin
         failures++;
         $display("FAIL wrap_counts got m=%0d u=%0d e=%0d want %0d/%0d/%0d", bus.match_count,
                  bus.unchecked_count, bus.err_count, m_match, m_unchk, m_err);
      end
   endtask

   task automatic test_spurious();
      apply_reset();
      ret_word(25'h5, 16'h1234);
      settle();
      checks++;
      if (bus.spurious_count !== 16'(m_spur) || bus.err_flag !== 1'b1 ||
          bus.pending_reads !== 10'd0) begin
         failures++;
         $display("FAIL spurious got s=%0d f=%b p=%0d want %0d/1/0",
                  bus.spurious_count, bus.err_flag, bus.pending_reads, m_spur);
      end
      checks++;
      if (bus.first_err_addr !== m_fa || bus.first_err_exp !== m_fe ||
          bus.first_err_got !== m_fg) begin
         failures++;
         $display("FAIL spurious_first_err got a=%h x=%h g=%h want %h/%h/%h",
                  bus.first_err_addr, bus.first_err_exp, bus.first_err_got, m_fa, m_fe, m_fg);
      end
   endtask

   task automatic test_unchecked();
      apply_reset();
      do_read(1'b0, 25'h200, 2'd0);
      ret_word(25'h200, 16'($urandom));
      bufd[0] = 16'($urandom);
      do_write(1'b0, 25'h100 + 25'(1 << AW), 2'd0);
      do_read(1'b0, 25'h100, 2'd0);
      ret_word(25'h100, bufd[0]);
      settle();
      checks++;
      if (bus.unchecked_count !== 16'(m_unchk) || bus.match_count !== 16'(m_match) ||
          bus.err_flag !== 1'b0) begin
         failures++;
         $display("FAIL unchecked got u=%0d m=%0d f=%b want %0d/%0d/0",
                  bus.unchecked_count, bus.match_count, bus.err_flag, m_unchk, m_match);
      end
   endtask

   task automatic test_net_update();
      apply_reset();
      do_read(1'b0, 25'h300, 2'd0);
      bus.cmd = 3'b001; bus.addr = 25'h301;
      m_pend++;
      ret_word(25'h300, 16'($urandom));
      bus.cmd = '0;
      checks++;
      if (bus.pending_reads !== 10'(m_pend)) begin
         failures++;
         $display("FAIL net_pending got %0d want %0d", bus.pending_reads, m_pend);
      end
   endtask

   task automatic test_reset_midburst();
      logic [24:0] a;
      apply_reset();
      a = 25'h400 + 25'($urandom_range(0, 63));
      for (int i = 0; i < 16; i++) bufd[i] = 16'($urandom);
      do_read(1'b0, 25'h777, 2'd0);
      @(negedge clk);
      bus.cmd = 3'b100; bus.addr = a; bus.sz = 2'd1;
      @(negedge clk);
      bus.cmd = '0;
      for (int i = 0; i < 4; i++) begin
         bus.fetching = 1'b1; bus.din = bufd[i];
         if (i == 3) #2; else @(negedge clk);
      end
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.idle !== 1'b1 || bus.pending_reads !== 10'd0 || bus.match_count !== 16'd0 ||
          bus.unchecked_count !== 16'd0) begin
         failures++;
         $display("FAIL midburst_reset got idle=%b p=%0d m=%0d u=%0d want 1/0/0/0",
                  bus.idle, bus.pending_reads, bus.match_count, bus.unchecked_count);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.fetching = 1'b0;
      do_read(1'b1, a, 2'd0);
      for (int i = 0; i < 8; i++) ret_word(a + 25'(i), bufd[i]);
      settle();
      checks++;
      if (bus.unchecked_count !== 16'(m_unchk) || bus.match_count !== 16'd0 ||
          bus.idle !== 1'b1) begin
         failures++;
         $display("FAIL midburst_readback got u=%0d m=%0d idle=%b want %0d/0/1",
                  bus.unchecked_count, bus.match_count, bus.idle, m_unchk);
      end
   endtask

   task automatic test_back_to_back();
      logic [24:0] wa, ra, a;
      logic [1:0]  ws, rs;
      logic [15:0] d;
      int idx;
      apply_reset();
      for (int it = 0; it < 8; it++) begin
         ws = 2'($urandom_range(0, 3));
         wa = 25'h800 + 25'($urandom_range(0, 63));
         for (int i = 0; i < 32; i++) bufd[i] = 16'($urandom);
         do_write(1'b1, wa, ws);
         rs = 2'($urandom_range(0, 1));
         ra = wa + 25'($urandom_range(0, 15));
         do_read(1'b1, ra, rs);
         checks++;
         if (bus.pending_reads !== 10'(m_pend)) begin
            failures++;
            $display("FAIL b2b_pending it=%0d got %0d want %0d", it, bus.pending_reads, m_pend);
         end
         for (int i = 0; i < 8 * (int'(rs) + 1); i++) begin
            a = ra + 25'(i);
            idx = int'(a[AW-1:0]);
            d = m_valid[idx] ? m_data[idx] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = d ^ 16'($urandom_range(1, 65535));
            ret_word(a, d);
         end
         settle();
         checks++;
         if (bus.match_count !== 16'(m_match) || bus.err_count !== 16'(m_err) ||
             bus.unchecked_count !== 16'(m_unchk) || bus.spurious_count !== 16'(m_spur)) begin
            failures++;
            $display("FAIL b2b_counts it=%0d got m=%0d e=%0d u=%0d s=%0d want %0d/%0d/%0d/%0d",
                     it, bus.match_count, bus.err_count, bus.unchecked_count,
                     bus.spurious_count, m_match, m_err, m_unchk, m_spur);
         end
      end
      checks++;
      if (bus.err_flag !== m_flag || (m_flag && (bus.first_err_addr !== m_fa ||
          bus.first_err_exp !== m_fe || bus.first_err_got !== m_fg))) begin
         failures++;
         $display("FAIL b2b_first_err got f=%b a=%h x=%h g=%h want %b/%h/%h/%h", bus.err_flag,
                  bus.first_err_addr, bus.first_err_exp, bus.first_err_got, m_flag, m_fa, m_fe, m_fg);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_burst_err();
      test_wrap();
      test_spurious();
      test_unchecked();
      test_net_update();
      test_reset_midburst();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
